// File: rtl/adder_pkg.sv
// Shared constants and sizing helper for the pipelined adder.
package adder_pkg;

  localparam int ADDER_WIDTH_DEF  = 16;
  localparam int ADDER_STAGES_DEF = 2;

  function automatic int chunk_width(input int width, input int stages);
    if (stages < 1) return width;
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One registered carry slice: adds two CHUNK-bit operand slices plus a carry,
// holding sum, carry out and the slot's valid flag while enable is low.
module adder_pipe_stage
  import adder_pkg::*;
#(
  parameter int CHUNK = chunk_width(ADDER_WIDTH_DEF, ADDER_STAGES_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             valid_in,
  input  logic [CHUNK-1:0] a_chunk,
  input  logic [CHUNK-1:0] b_chunk,
  input  logic             carry_in,
  output logic             valid_out,
  output logic [CHUNK-1:0] sum_chunk,
  output logic             carry_out
);

  logic           valid_q, valid_d;
  logic [CHUNK:0] slice_q, slice_d;

  always_comb begin
    valid_d = valid_in;
    slice_d = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK+1)'(carry_in);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      slice_q <= '0;
    end else if (enable) begin
      valid_q <= valid_d;
      slice_q <= slice_d;
    end
  end

  assign valid_out = valid_q;
  assign sum_chunk = slice_q[CHUNK-1:0];
  assign carry_out = slice_q[CHUNK];

endmodule

// File: rtl/adder_pipe_nbit.sv
// Pipelined ripple-carry adder, one carry chunk per stage, valid/ready handshake.
// Define ADDER_PIPE_SATURATE_EN to clamp sum to all ones on final carry out.
module adder_pipe_nbit
  import adder_pkg::*;
#(
  parameter int WIDTH  = ADDER_WIDTH_DEF,
  parameter int STAGES = ADDER_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);
  localparam int NDLY  = (STAGES > 1) ? STAGES - 1 : 1;

  if ((STAGES < 1) || ((WIDTH % ((STAGES < 1) ? 1 : STAGES)) != 0)) begin : g_cfg_err
    $error("adder_pipe_nbit: STAGES must be >= 1 and divide WIDTH");
  end

  logic             adv;
  logic [WIDTH-1:0] a_in    [STAGES];
  logic [WIDTH-1:0] b_in    [STAGES];
  logic             cin_stg [STAGES];
  logic             vin_stg [STAGES];
  logic             valid_stg [STAGES];
  logic             carry_stg [STAGES];
  logic [CHUNK-1:0] chunk_stg [STAGES];
  logic [WIDTH-1:0] res_vec [STAGES];

  // Operands are pre-shifted so each stage always reads its slice at bit 0;
  // finished chunks enter res at the top and shift down one chunk per stage.
  logic [WIDTH-1:0] a_dly_q [NDLY], a_dly_d [NDLY];
  logic [WIDTH-1:0] b_dly_q [NDLY], b_dly_d [NDLY];
  logic [WIDTH-1:0] res_lo_q [NDLY], res_lo_d [NDLY];

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        a_in[k]    = a;
        b_in[k]    = b;
        cin_stg[k] = carry_in;
        vin_stg[k] = in_valid;
        res_vec[k] = '0;
      end else begin
        a_in[k]    = a_dly_q[(k > 0) ? k - 1 : 0];
        b_in[k]    = b_dly_q[(k > 0) ? k - 1 : 0];
        cin_stg[k] = carry_stg[(k > 0) ? k - 1 : 0];
        vin_stg[k] = valid_stg[(k > 0) ? k - 1 : 0];
        res_vec[k] = res_lo_q[(k > 0) ? k - 1 : 0];
      end
      res_vec[k][WIDTH-CHUNK +: CHUNK] = chunk_stg[k];
    end
    for (int d = 0; d < NDLY; d++) begin
      a_dly_d[d]  = a_in[d] >> CHUNK;
      b_dly_d[d]  = b_in[d] >> CHUNK;
      res_lo_d[d] = res_vec[d] >> CHUNK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < NDLY; d++) begin
        a_dly_q[d]  <= '0;
        b_dly_q[d]  <= '0;
        res_lo_q[d] <= '0;
      end
    end else if (adv) begin
      for (int d = 0; d < NDLY; d++) begin
        a_dly_q[d]  <= a_dly_d[d];
        b_dly_q[d]  <= b_dly_d[d];
        res_lo_q[d] <= res_lo_d[d];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_pipe_stage #(.CHUNK(CHUNK)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .enable    (adv),
      .valid_in  (vin_stg[k]),
      .a_chunk   (a_in[k][CHUNK-1:0]),
      .b_chunk   (b_in[k][CHUNK-1:0]),
      .carry_in  (cin_stg[k]),
      .valid_out (valid_stg[k]),
      .sum_chunk (chunk_stg[k]),
      .carry_out (carry_stg[k])
    );
  end

  assign out_valid = valid_stg[STAGES-1];
  assign overflow  = carry_stg[STAGES-1];

`ifdef ADDER_PIPE_SATURATE_EN
  assign sum = carry_stg[STAGES-1] ? {WIDTH{1'b1}} : res_vec[STAGES-1];
`else
  assign sum = res_vec[STAGES-1];
`endif

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Directed + random bench for adder_pipe_nbit with a queue-based reference model.
module tb_adder_pipe_nbit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, carry_in, out_valid, out_ready, overflow;
  logic [15:0] a, b, sum;

  logic        iv6, cin6, or6;
  logic [15:0] a6, b6;
  logic        ir1, ov1, ovf1, ir4, ov4, ovf4;
  logic [15:0] sum1, sum4;

  int          n_total = 0;
  int          n_pass  = 0;
  int          cyc     = 0;
  int          n_out   = 0;
  int          first_cyc = -1;
  int          last_cyc  = -1;
  logic [16:0] q[$];

  always #5 clk = ~clk;

  adder_pipe_nbit #(.WIDTH(16), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carry_in(carry_in), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .overflow(overflow)
  );

  adder_pipe_nbit #(.WIDTH(16), .STAGES(1)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(iv6), .in_ready(ir1),
    .a(a6), .b(b6), .carry_in(cin6), .out_valid(ov1),
    .out_ready(or6), .sum(sum1), .overflow(ovf1)
  );

  adder_pipe_nbit #(.WIDTH(16), .STAGES(4)) dut_s4 (
    .clk(clk), .rst(rst), .in_valid(iv6), .in_ready(ir4),
    .a(a6), .b(b6), .carry_in(cin6), .out_valid(ov4),
    .out_ready(or6), .sum(sum4), .overflow(ovf4)
  );

  // Reference: full-precision sum, bit 16 is the carry out.
  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c);
    logic [16:0] r;
    r = {1'b0, x} + {1'b0, y} + {16'd0, c};
`ifdef ADDER_PIPE_SATURATE_EN
    if (r[16]) r[15:0] = 16'hFFFF;
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Evaluates both handshakes for the coming edge, then advances one cycle.
  task automatic tick();
    logic [16:0] e;
    #1;
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk("result_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("result", {15'd0, overflow, sum}, {15'd0, e});
        end
        n_out++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      if (in_valid && in_ready) q.push_back(model(a, b, carry_in));
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int lat, lat1, lat4;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; carry_in = 1'b0;
    iv6 = 1'b0; or6 = 1'b1; a6 = '0; b6 = '0; cin6 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // carry across the chunk boundary, and latency
    a = 16'h00FF; b = 16'h0001; carry_in = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin tick(); lat++; end
    chk("t1_latency", 32'(lat), 32'd2);
    chk("t1_sum", 32'(sum), 32'h0100);
    chk("t1_overflow", 32'(overflow), 32'd0);
    tick();

    // final carry out
    a = 16'hFFFF; b = 16'h0001; carry_in = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
`ifdef ADDER_PIPE_SATURATE_EN
    chk("t2_sum", 32'(sum), 32'hFFFF);
`else
    chk("t2_sum", 32'(sum), 32'h0000);
`endif
    chk("t2_overflow", 32'(overflow), 32'd1);
    tick();

    // back-to-back stream
    n_out = 0; first_cyc = -1; last_cyc = -1;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom); b = 16'($urandom); carry_in = 1'($urandom);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    chk("t3_count", 32'(n_out), 32'd8);
    chk("t3_consecutive", 32'(last_cyc - first_cyc), 32'd7);

    // stall with a full pipe
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10 && in_ready; i++) begin
      a = 16'($urandom); b = 16'($urandom); carry_in = 1'($urandom);
      tick();
    end
    chk("t4_full_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      tick();
      chk("t4_stall_in_ready", 32'(in_ready), 32'd0);
      chk("t4_stall_valid", 32'(out_valid), 32'd1);
      chk("t4_stall_hold", {15'd0, overflow, sum}, (q.size() != 0) ? {15'd0, q[0]} : 32'hDEAD);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    repeat (4) tick();
    chk("t4_drained", 32'(q.size()), 32'd0);

    // reset with two items in flight
    for (int i = 0; i < 2; i++) begin
      a = 16'($urandom); b = 16'($urandom); carry_in = 1'($urandom);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    tick();
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_sum", 32'(sum), 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 16'($urandom); b = 16'($urandom); carry_in = 1'($urandom);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    chk("t5_drained", 32'(q.size()), 32'd0);

    // random traffic with random consumer stalls
    for (int i = 0; i < 60; i++) begin
      a = 16'($urandom); b = 16'($urandom); carry_in = 1'($urandom);
      in_valid = 1'($urandom);
      out_ready = ($urandom_range(3) != 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) tick();
    chk("rand_drained", 32'(q.size()), 32'd0);

    // degenerate and deep builds
    a6 = 16'h7FFF; b6 = 16'h7FFF; cin6 = 1'b1; iv6 = 1'b1;
    tick();
    iv6 = 1'b0;
    lat1 = 0; lat4 = 0;
    for (int i = 1; i <= 8; i++) begin
      if (ov1 && lat1 == 0) begin
        lat1 = i;
        chk("t6_s1_sum", 32'(sum1), 32'hFFFF);
        chk("t6_s1_overflow", 32'(ovf1), 32'd0);
      end
      if (ov4 && lat4 == 0) begin
        lat4 = i;
        chk("t6_s4_sum", 32'(sum4), 32'hFFFF);
        chk("t6_s4_overflow", 32'(ovf4), 32'd0);
      end
      tick();
    end
    chk("t6_s1_latency", 32'(lat1), 32'd1);
    chk("t6_s4_latency", 32'(lat4), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
